// File: rtl/counter_check_pkg.sv
// rtl/counter_check_pkg.sv - FSM state encoding and successor helper for the sequence checker
`timescale 1ns/1ps
package counter_check_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Caller truncates the result to its own width, which drops any carry.
  function automatic logic [31:0] successor(input logic [31:0] prev, input logic [31:0] max_val);
    if (prev == max_val) return 32'd0;
    return prev + 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
`timescale 1ns/1ps
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_COUNT = {W{1'b1}};

  // A clear that coincides with an event keeps that event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != MAX_COUNT)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/counter_sequence_checker.sv
// rtl/counter_sequence_checker.sv - locks onto an incrementing count stream and flags breaks
`timescale 1ns/1ps
module counter_sequence_checker
  import counter_check_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic             illegal_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  localparam logic [31:0] MAX_U  = 32'(MAX_VAL);
  localparam logic [4:0]  LOCK_U = 5'(LOCK_CNT);

  state_t           state, state_n;
  logic [4:0]       run, run_n;
  logic [WIDTH-1:0] prev, prev_n;
  logic [WIDTH-1:0] succ_prev;
  logic             illegal, match;
  logic             err_n, ill_n;

  assign illegal   = 32'(count_in) > MAX_U;
  assign succ_prev = WIDTH'(successor(32'(prev), MAX_U));
  assign match     = (count_in == succ_prev);

  // run counts the first sample plus each correct step, so lock needs LOCK_CNT+1.
  always_comb begin
    state_n = state;
    run_n   = run;
    prev_n  = prev;
    err_n   = 1'b0;
    ill_n   = 1'b0;
    if (sample_en) begin
      ill_n = illegal;
      case (state)
        SEARCH: begin
          if (!illegal) begin
            prev_n  = count_in;
            run_n   = 5'd1;
            state_n = ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (illegal) begin
            run_n   = 5'd0;
            state_n = SEARCH;
          end else if (match) begin
            run_n  = run + 5'd1;
            prev_n = count_in;
            if (run + 5'd1 > LOCK_U) state_n = LOCKED;
          end else begin
            run_n  = 5'd1;
            prev_n = count_in;
          end
        end
        LOCKED: begin
          if (illegal) begin
            err_n   = 1'b1;
            run_n   = 5'd0;
            state_n = SEARCH;
          end else if (!match) begin
            err_n   = 1'b1;
            run_n   = 5'd1;
            prev_n  = count_in;
            state_n = ACQUIRE;
          end else begin
            prev_n = count_in;
          end
        end
        default: begin
          run_n   = 5'd0;
          state_n = SEARCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= SEARCH;
      run           <= 5'd0;
      prev          <= '0;
      expected      <= WIDTH'(1);
      locked        <= 1'b0;
      err_pulse     <= 1'b0;
      illegal_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      run           <= run_n;
      prev          <= prev_n;
      expected      <= WIDTH'(successor(32'(prev_n), MAX_U));
      locked        <= (state_n == LOCKED);
      err_pulse     <= err_n;
      illegal_pulse <= ill_n;
    end
  end

  sat_counter #(.W(ERR_W)) u_err_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_n),
    .clr   (clear_err),
    .count (err_count)
  );

endmodule

// File: tb/tb_counter_sequence_checker.sv
// tb/tb_counter_sequence_checker.sv - directed self-checking bench for counter_sequence_checker
`timescale 1ns/1ps
module tb_counter_sequence_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       a_en = 1'b0, a_clr = 1'b0;
  logic [3:0] a_cnt = 4'd0;
  logic       a_locked, a_err, a_ill;
  logic [7:0] a_ecnt;
  logic [3:0] a_exp;

  logic       b_en = 1'b0, b_clr = 1'b0;
  logic [3:0] b_cnt = 4'd0;
  logic       b_locked, b_err, b_ill, c_locked, c_err, c_ill;
  logic [7:0] b_ecnt, c_ecnt;
  logic [3:0] b_exp, c_exp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_sequence_checker dut_a (
    .clk(clk), .rst(rst), .sample_en(a_en), .count_in(a_cnt), .clear_err(a_clr),
    .locked(a_locked), .err_pulse(a_err), .illegal_pulse(a_ill),
    .err_count(a_ecnt), .expected(a_exp)
  );

  counter_sequence_checker #(.WIDTH(4), .MAX_VAL(9), .LOCK_CNT(3), .ERR_W(8)) dut_b (
    .clk(clk), .rst(rst), .sample_en(b_en), .count_in(b_cnt), .clear_err(b_clr),
    .locked(b_locked), .err_pulse(b_err), .illegal_pulse(b_ill),
    .err_count(b_ecnt), .expected(b_exp)
  );

  counter_sequence_checker #(.WIDTH(4), .MAX_VAL(9), .LOCK_CNT(1), .ERR_W(8)) dut_c (
    .clk(clk), .rst(rst), .sample_en(b_en), .count_in(b_cnt), .clear_err(b_clr),
    .locked(c_locked), .err_pulse(c_err), .illegal_pulse(c_ill),
    .err_count(c_ecnt), .expected(c_exp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step_a(input logic en, input logic [3:0] v, input logic clr);
    a_en = en; a_cnt = v; a_clr = clr;
    @(posedge clk); #1;
    a_en = 1'b0; a_clr = 1'b0;
  endtask

  task automatic step_b(input logic en, input logic [3:0] v);
    b_en = en; b_cnt = v;
    @(posedge clk); #1;
    b_en = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_locked", a_locked, 0);
    chk("rst_err", a_err, 0);
    chk("rst_ill", a_ill, 0);
    chk("rst_ecnt", a_ecnt, 0);
    chk("rst_exp", a_exp, 1);
    rst = 1'b0;

    // MAX_VAL=9 instances: illegal in SEARCH, lock, wrap, illegal break, relock
    step_b(1, 12);
    chk("b_search_ill", b_ill, 1);
    chk("b_search_locked", b_locked, 0);
    chk("b_search_exp", b_exp, 1);
    chk("c_search_ill", c_ill, 1);
    step_b(1, 6);
    chk("b_acq_exp", b_exp, 7);
    chk("b_acq_ill", b_ill, 0);
    step_b(1, 7);
    chk("c_lock1", c_locked, 1);
    chk("b_not_yet", b_locked, 0);
    step_b(1, 8);
    chk("b_not_yet2", b_locked, 0);
    step_b(1, 9);
    chk("b_locked9", b_locked, 1);
    chk("b_exp_wrap", b_exp, 0);
    step_b(1, 12);
    chk("b_brk_err", b_err, 1);
    chk("b_brk_ill", b_ill, 1);
    chk("b_brk_locked", b_locked, 0);
    chk("b_brk_ecnt", b_ecnt, 1);
    chk("c_brk_err", c_err, 1);
    step_b(1, 0);
    chk("b_reacq_exp", b_exp, 1);
    step_b(1, 15);
    chk("b_acq_ill_pulse", b_ill, 1);
    chk("b_acq_ill_noerr", b_err, 0);
    chk("b_acq_ill_ecnt", b_ecnt, 1);
    step_b(1, 0);
    step_b(1, 1);
    chk("c_relock", c_locked, 1);
    chk("b_relock_early", b_locked, 0);
    step_b(1, 2);
    step_b(1, 3);
    chk("b_relock", b_locked, 1);
    chk("b_relock_exp", b_exp, 4);
    chk("b_relock_err", b_err, 0);
    chk("a_idle_exp", a_exp, 1);
    chk("a_idle_locked", a_locked, 0);

    // default instance: acquire 5,6,7,8
    step_a(1, 5, 0);
    step_a(1, 6, 0);
    step_a(1, 7, 0);
    chk("a_pre_lock", a_locked, 0);
    step_a(1, 8, 0);
    chk("a_lock8", a_locked, 1);
    chk("a_lock8_ecnt", a_ecnt, 0);
    chk("a_lock8_exp", a_exp, 9);
    for (int v = 9; v <= 14; v++) step_a(1, 4'(v), 0);
    step_a(1, 15, 0);
    chk("a_15_locked", a_locked, 1);
    chk("a_15_exp", a_exp, 0);
    step_a(1, 0, 0);
    chk("a_wrap_locked", a_locked, 1);
    chk("a_wrap_err", a_err, 0);
    step_a(1, 1, 0);
    chk("a_1_ill", a_ill, 0);
    chk("a_1_exp", a_exp, 2);
    step_a(1, 2, 0);
    step_a(1, 3, 0);
    step_a(1, 7, 0);
    chk("a_brk_err", a_err, 1);
    chk("a_brk_ecnt", a_ecnt, 1);
    chk("a_brk_locked", a_locked, 0);
    chk("a_brk_exp", a_exp, 8);
    step_a(0, 0, 0);
    chk("a_idle_err", a_err, 0);
    chk("a_idle_exp8", a_exp, 8);
    chk("a_idle_ecnt", a_ecnt, 1);

    // drive the error counter to saturation
    for (int i = 0; i < 254; i++) begin
      step_a(1, 0, 0); step_a(1, 1, 0); step_a(1, 2, 0); step_a(1, 3, 0);
      step_a(1, 9, 0);
    end
    chk("a_ecnt_255", a_ecnt, 255);
    step_a(1, 0, 0); step_a(1, 1, 0); step_a(1, 2, 0); step_a(1, 3, 0);
    step_a(1, 9, 0);
    chk("a_sat_err", a_err, 1);
    chk("a_sat_hold", a_ecnt, 255);
    step_a(1, 0, 0); step_a(1, 1, 0); step_a(1, 2, 0); step_a(1, 3, 0);
    step_a(1, 9, 1);
    chk("a_clr_with_err", a_ecnt, 1);
    step_a(0, 0, 1);
    chk("a_clr_plain", a_ecnt, 0);

    // relock, log one error, relock, then reset asynchronously
    step_a(1, 0, 0); step_a(1, 1, 0); step_a(1, 2, 0); step_a(1, 3, 0);
    chk("a_relock", a_locked, 1);
    step_a(1, 5, 0);
    chk("a_err2_ecnt", a_ecnt, 1);
    step_a(1, 6, 0); step_a(1, 7, 0); step_a(1, 8, 0);
    chk("a_relock2", a_locked, 1);
    #3 rst = 1'b1;
    #1;
    chk("async_locked", a_locked, 0);
    chk("async_exp", a_exp, 1);
    chk("async_ecnt", a_ecnt, 0);
    chk("async_b_locked", b_locked, 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step_a(0, 0, 0);
      chk("idle_locked", a_locked, 0);
      chk("idle_exp", a_exp, 1);
      chk("idle_pulses", {a_err, a_ill}, 0);
    end
    step_a(1, 3, 0);
    chk("post_rst_search", a_locked, 0);
    chk("post_rst_exp", a_exp, 4);
    step_a(1, 4, 0); step_a(1, 5, 0); step_a(1, 6, 0);
    chk("post_rst_lock", a_locked, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
